ascii_uart_rx: RTL and testbench

ASCII_UART_RX -- requirements
Module: ascii_uart_rx

---
 rtl/ascii_uart_rx_pkg.sv | 37 +++
 rtl/ascii_uart_rx_if.sv | 24 ++
 rtl/uart_baud_timer.sv | 37 +++
 rtl/ascii_uart_rx.sv | 128 ++++++++++++
 tb/tb_ascii_uart_rx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding, bit-timing derivation
// and the byte acceptance filter.
package ascii_uart_rx_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;
    localparam int DEFAULT_BAUD   = 115_200;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    // Clock cycles per serial bit (integer division, 434 at the defaults)
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Offset from a bit edge to its mid-point sample (217 at the defaults)
    function automatic int calc_half_bit(input int clk_hz, input int baud);
        return calc_clks_per_bit(clk_hz, baud) / 2;
    endfunction

    // Counter width able to hold CLKS_PER_BIT-1 without wrapping early
    function automatic int calc_timer_width(input int clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

    // Byte filter: with digits_only set, only ASCII '0'..'9' are forwarded
    function automatic logic byte_accepted(input logic [7:0] b, input logic digits_only);
        return (!digits_only) || ((b >= 8'h30) && (b <= 8'h39));
    endfunction

endpackage

// File: rtl/ascii_uart_rx_if.sv
// Bus bundle between the serial line driver and the ASCII receiver:
// the RX line in, received byte with its strobe and the framing-error strobe out.
interface ascii_uart_rx_if;
    logic       RX;
    logic [7:0] D;
    logic       ASCIIEnable;
    logic       FrameError;

    // Side that drives the serial line and consumes received bytes
    modport master (
        output RX,
        input  D,
        input  ASCIIEnable,
        input  FrameError
    );

    // Receiver side
    modport slave (
        input  RX,
        output D,
        output ASCIIEnable,
        output FrameError
    );
endinterface

// File: rtl/uart_baud_timer.sv
// Free-running bit timer: counts 0..CLKS_PER_BIT-1 and restarts from zero on
// request. Strobes mark the mid-bit sample point and the last cycle of a bit,
// so a receiver and a transmitter can share the same timing block.
module uart_baud_timer
    import ascii_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = 217
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_mid_bit,
    output logic o_end_bit
);

    localparam int W = calc_timer_width(CLKS_PER_BIT);
    localparam logic [W-1:0] MID_COUNT = W'(HALF_BIT - 1);
    localparam logic [W-1:0] END_COUNT = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_count;

    // Count cycles within a bit; restart aligns count 0 with the detected edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_restart || (r_count == END_COUNT)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_mid_bit = (r_count == MID_COUNT);
    assign o_end_bit = (r_count == END_COUNT);

endmodule

// File: rtl/ascii_uart_rx.sv
// 8N1 UART receiver that forwards (optionally digit-only) ASCII bytes.
// D and ASCIIEnable are registered so they can feed an accumulator's data and
// enable inputs directly; FrameError flags a stop bit sampled low.
module ascii_uart_rx
    import ascii_uart_rx_pkg::*;
#(
    parameter int CLK_HZ      = DEFAULT_CLK_HZ,
    parameter int BAUD        = DEFAULT_BAUD,
    parameter bit DIGITS_ONLY = 1'b1
) (
    input  logic           CLOCK_50,
    input  logic           Reset_n,
    ascii_uart_rx_if.slave bus
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF_BIT     = calc_half_bit(CLK_HZ, BAUD);

    rx_state_t  r_state;
    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic [7:0] r_d;
    logic       r_ascii_en;
    logic       r_frame_err;

    logic       w_rx;
    logic       w_restart;
    logic       w_mid_bit;
    logic       w_end_bit_unused;   // end-of-bit strobe is only needed by a transmitter

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.RX;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    // The bit timer is zeroed on the same edge that recognises the start edge,
    // so every later mid_bit strobe lands in the middle of a bit.
    assign w_restart = (r_state == IDLE) && !w_rx;

    uart_baud_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .HALF_BIT     (HALF_BIT)
    ) u_baud_timer (
        .clk       (CLOCK_50),
        .rst_n     (Reset_n),
        .i_restart (w_restart),
        .o_mid_bit (w_mid_bit),
        .o_end_bit (w_end_bit_unused)
    );

    // Frame FSM with registered byte/strobe outputs
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_d         <= 8'h00;
            r_ascii_en  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // strobes default low so each lasts exactly one cycle
            r_ascii_en  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        r_state <= START;
                    end
                end
                START: begin
                    r_bit_idx <= 3'd0;
                    if (w_mid_bit) begin
                        // a line already back high at mid-start is a glitch
                        r_state <= w_rx ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_mid_bit) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_mid_bit) begin
                        if (w_rx) begin
                            if (byte_accepted(r_shift, DIGITS_ONLY)) begin
                                r_d        <= r_shift;
                                r_ascii_en <= 1'b1;
                            end
                            // leave at mid-stop so a back-to-back start edge is caught
                            r_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (w_rx) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.D           = r_d;
    assign bus.ASCIIEnable = r_ascii_en;
    assign bus.FrameError  = r_frame_err;

endmodule

// File: tb/tb_ascii_uart_rx.sv
// Bench for ascii_uart_rx: a digit-filtering and an unfiltered receiver share
// one serial line; a reference model of accepted bytes and frame errors is
// compared against strobes collected from both receivers.
module tb_ascii_uart_rx;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115_200;
    localparam int CPB    = CLK_HZ / BAUD;                 // 434
    localparam int LAT    = (CPB / 2) + 9 * CPB + 1 + 2;   // 4126 from the pin edge

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    int   cyc   = 0;

    ascii_uart_rx_if bus0 ();
    ascii_uart_rx_if bus1 ();

    assign bus0.RX = rx;
    assign bus1.RX = rx;

    ascii_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DIGITS_ONLY(1'b1)) dut_dig (
        .CLOCK_50 (clk),
        .Reset_n  (rst_n),
        .bus      (bus0)
    );

    ascii_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DIGITS_ONLY(1'b0)) dut_all (
        .CLOCK_50 (clk),
        .Reset_n  (rst_n),
        .bus      (bus1)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- strobe collection ----------------
    logic [7:0] q_d0[$];
    logic [7:0] q_d1[$];
    int         q_c0[$];
    int         fe0   = 0;
    int         fe1   = 0;
    int         viol  = 0;
    logic       p_en0 = 1'b0, p_fe0 = 1'b0, p_en1 = 1'b0, p_fe1 = 1'b0;

    always @(negedge clk) begin
        if (bus0.ASCIIEnable === 1'b1) begin
            q_d0.push_back(bus0.D);
            q_c0.push_back(cyc);
        end
        if (bus1.ASCIIEnable === 1'b1) q_d1.push_back(bus1.D);
        if (bus0.FrameError === 1'b1) fe0 <= fe0 + 1;
        if (bus1.FrameError === 1'b1) fe1 <= fe1 + 1;
        if ((bus0.ASCIIEnable && bus0.FrameError) || (bus0.ASCIIEnable && p_en0) ||
            (bus0.FrameError && p_fe0) || (bus1.ASCIIEnable && bus1.FrameError) ||
            (bus1.ASCIIEnable && p_en1) || (bus1.FrameError && p_fe1))
            viol <= viol + 1;
        p_en0 <= bus0.ASCIIEnable;
        p_fe0 <= bus0.FrameError;
        p_en1 <= bus1.ASCIIEnable;
        p_fe1 <= bus1.FrameError;
    end

    // ---------------- reference model ----------------
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] mdl_d0 = 8'h00;
    logic [7:0] mdl_d1 = 8'h00;
    int         exp_fe = 0;
    int         rd0    = 0;
    int         rd1    = 0;
    int         checks = 0;
    int         errors = 0;
    int         start_cyc = 0;

    function automatic bit is_digit(input logic [7:0] b);
        return (b >= "0") && (b <= "9");
    endfunction

    // Model outcome of one complete frame on both receivers
    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_fe = exp_fe + 1;
        end else begin
            if (is_digit(b)) begin
                exp0.push_back(b);
                mdl_d0 = b;
            end
            exp1.push_back(b);
            mdl_d1 = b;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame; b2b starts immediately where the previous frame ended
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit b2b);
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        rx        = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx = stop_ok;
        repeat (CPB) @(posedge clk);
        #1;
        if (stop_ok) rx = 1'b1;
        model_frame(b, stop_ok);
    endtask

    // Compare everything collected since the previous call against the model
    task automatic check_state(input string tag);
        chk({tag, " dig strobe count"}, q_d0.size(), exp0.size());
        for (int i = rd0; i < exp0.size(); i++)
            if (i < q_d0.size()) chk({tag, " dig byte"}, q_d0[i], exp0[i]);
        rd0 = exp0.size();
        chk({tag, " all strobe count"}, q_d1.size(), exp1.size());
        for (int i = rd1; i < exp1.size(); i++)
            if (i < q_d1.size()) chk({tag, " all byte"}, q_d1[i], exp1[i]);
        rd1 = exp1.size();
        chk({tag, " dig D"}, bus0.D, mdl_d0);
        chk({tag, " all D"}, bus1.D, mdl_d1);
        chk({tag, " dig frame errors"}, fe0, exp_fe);
        chk({tag, " all frame errors"}, fe1, exp_fe);
        $display("[%0d] %s: dig D=0x%02h all D=0x%02h strobes=%0d/%0d fe=%0d",
                 cyc, tag, bus0.D, bus1.D, q_d0.size(), q_d1.size(), fe0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " dig D"}, bus0.D, 8'h00);
        chk({tag, " all D"}, bus1.D, 8'h00);
        chk({tag, " strobes"}, {bus0.ASCIIEnable, bus0.FrameError, bus1.ASCIIEnable, bus1.FrameError}, 4'b0000);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] b39;

        // reset state
        #5;
        check_outputs_zero("reset");
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("first cycle after release");
        repeat (20) @(posedge clk);

        // '5' with latency measurement
        send_byte(8'h35, 1'b1, 1'b0);
        chk("latency '5'", (q_c0.size() > 0) ? (q_c0[0] - start_cyc) : -1, LAT);
        check_state("send 0x35");

        // non-digit 'A'
        send_byte(8'h41, 1'b1, 1'b0);
        check_state("send 0x41");

        // '7' with stop bit low, line held low, then recovery with '8'
        send_byte(8'h37, 1'b0, 1'b0);
        repeat (2000) @(posedge clk);
        #1 rx = 1'b1;
        repeat (CPB) @(posedge clk);
        check_state("send 0x37 bad stop");
        send_byte(8'h38, 1'b1, 1'b0);
        check_state("send 0x38");

        // 100-cycle glitch, then '0'
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (100) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        check_state("glitch 100 cycles");
        send_byte(8'h30, 1'b1, 1'b0);
        check_state("send 0x30");

        // back-to-back '1','2'
        send_byte(8'h31, 1'b1, 1'b0);
        send_byte(8'h32, 1'b1, 1'b1);
        check_state("back-to-back 0x31 0x32");

        // reset during data bit 4 of '9'
        b39 = 8'h39;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx = b39[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx = b39[4];
        repeat (CPB / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("async reset mid-frame");
        mdl_d0 = 8'h00;
        mdl_d1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        check_outputs_zero("release after mid-frame reset");
        repeat (2 * CPB) @(posedge clk);
        check_state("after reset abort");
        send_byte(8'h34, 1'b1, 1'b0);
        check_state("send 0x34");

        // randomized frames, roughly half digits
        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(0, 1) == 1) rb = 8'(8'h30 + $urandom_range(0, 9));
            else                           rb = 8'($urandom_range(0, 255));
            send_byte(rb, 1'b1, 1'b0);
            check_state($sformatf("random 0x%02h", rb));
        end

        chk("strobe exclusivity/width", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
